coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive stable synchronized samples after first detection; legal range 2..15.
REQ-002 The block SHALL have parameter GAP, default 2, meaning holdoff cycles after release during which sensors are ignored; legal range 1..15.
REQ-003 The block SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port sense5  input  1  raw, asynchronous 5-cent slot sensor.
REQ-006 The block SHALL have port sense10  input  1  raw, asynchronous 10-cent slot sensor.
REQ-007 The block SHALL have port coin  output  2  coin code for the downstream vending controller: 00 none, 01 5-cent, 10 10-cent; never 11.
REQ-008 The block SHALL have port reject  output  1  one-cycle pulse for an invalid insertion, i.e. both sensors stable high.
REQ-009 The block SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 Each sensor SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the 2-bit synchronized sample {s10,s5}.
REQ-011 The FSM SHALL have states IDLE, QUAL, EMIT, RELEASE and HOLDOFF, and a shared 4-bit counter cnt.
REQ-012 In IDLE with a nonzero sample, the block SHALL capture the sample as pat, set cnt=1, and go to QUAL; with a zero sample it SHALL stay in IDLE.
REQ-013 In QUAL:
- sample==pat and cnt<DEBOUNCE: cnt SHALL increment.
- sample==pat and cnt==DEBOUNCE: go to EMIT.
- sample!=pat: return to IDLE and clear cnt, with no output (glitch rejection).
REQ-014 On the edge entering EMIT, coin SHALL be registered as follows:
- pat 01: coin=01.
- pat 10: coin=10.
- pat 11: coin=00 and reject=1.
REQ-015 coin and reject SHALL be high for exactly one cycle (the EMIT cycle) and SHALL return to 00/0 on the following edge; EMIT SHALL always go to RELEASE.
REQ-016 Latency: if a raw sensor is high at edges k..k+DEBOUNCE+1, coin SHALL be valid in the cycle following edge k+DEBOUNCE+2.
REQ-017 A raw pulse high for DEBOUNCE cycles or fewer SHALL produce no coin and no reject.
REQ-018 In RELEASE, a zero sample SHALL increment cnt, and a nonzero sample SHALL clear cnt.
REQ-019 When RELEASE reaches cnt==DEBOUNCE, the block SHALL go to HOLDOFF with cnt=0; a sensor held high indefinitely SHALL produce exactly one coin.
REQ-020 HOLDOFF SHALL last exactly GAP cycles regardless of the sensors, then return to IDLE.
REQ-021 A sample change from 01 to 11 during QUAL SHALL be treated as a glitch (return to IDLE), not as a 5-cent coin.

Reset
REQ-022 While reset is high at a rising edge, the block SHALL force the following, overriding all other activity, including mid-QUAL and mid-EMIT:
- synchronizers 0, state IDLE, cnt 0, pat 00.
- coin 00, reject 0, busy 0.
REQ-023 A coin being qualified when reset asserts SHALL be discarded; after reset deasserts, a still-high sensor SHALL be qualified from scratch.

Configuration
REQ-024 When macro COIN_TALLY_EN is defined, the block SHALL add input tally_clr (1 bit, synchronous) and output tally (8 bits, running total in 5-cent units).
REQ-025 With COIN_TALLY_EN defined, tally SHALL behave as follows:
- EMIT with coin 01 adds 1; coin 10 adds 2; reject adds 0.
- Saturates at 255.
- tally_clr in the same cycle as EMIT yields the value of that coin alone.
- Reset clears tally to 0.
REQ-026 Without COIN_TALLY_EN, tally_clr, tally and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE=4, GAP=2)
REQ-027 Bench SHALL cover: reset, then sense5 high for 20 cycles from edge 10 -> coin=01 only in the cycle after edge 16; no second coin.
REQ-028 Bench SHALL cover: sense10 high for 4 cycles -> coin stays 00, reject stays 0, busy returns low.
REQ-029 Bench SHALL cover: sense5 and sense10 both high for 10 cycles -> reject=1 for one cycle, coin stays 00.
REQ-030 Bench SHALL cover: sense10 high for 8 cycles, low for 1 cycle, high again (bounce during RELEASE) -> exactly one coin=10.
REQ-031 Bench SHALL cover: reset asserted for 1 cycle at edge 14 during a 5-cent qualification -> no coin before reset; coin=01 six cycles after the reset cycle if sense5 stays high.
REQ-032 With COIN_TALLY_EN, bench SHALL cover 130 ten-cent coins -> tally saturates at 255; tally_clr with a 5-cent EMIT -> tally=1.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes two slot sensors, debounces them and emits one coin code per insertion.
// Optional running tally of accepted value when COIN_TALLY_EN is defined.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int GAP      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense5,
  input  logic       sense10,
`ifdef COIN_TALLY_EN
  input  logic       tally_clr,
  output logic [7:0] tally,
`endif
  output logic [1:0] coin,
  output logic       reject,
  output logic       busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] QUAL    = 3'd1;
  localparam logic [2:0] EMIT    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] HOLDOFF = 3'd4;

  localparam logic [3:0] DB = 4'(DEBOUNCE);
  localparam logic [3:0] GP = 4'(GAP);

  logic [1:0] s5_q;
  logic [1:0] s10_q;
  logic [1:0] sample;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [1:0] pat;

  always_ff @(posedge clock) begin
    if (reset) begin
      s5_q  <= 2'b00;
      s10_q <= 2'b00;
    end else begin
      s5_q  <= {s5_q[0], sense5};
      s10_q <= {s10_q[0], sense10};
    end
  end

  assign sample = {s10_q[1], s5_q[1]};
  assign busy   = (state != IDLE);

  // coin/reject default low every cycle, so they pulse only in EMIT
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      pat    <= 2'b00;
      coin   <= 2'b00;
      reject <= 1'b0;
    end else begin
      coin   <= 2'b00;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (sample != 2'b00) begin
            pat   <= sample;
            cnt   <= 4'd1;
            state <= QUAL;
          end
        end
        QUAL: begin
          if (sample != pat) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == DB) begin
            state  <= EMIT;
            cnt    <= 4'd0;
            coin   <= (pat == 2'b11) ? 2'b00 : pat;
            reject <= (pat == 2'b11);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        EMIT: begin
          state <= RELEASE;
          cnt   <= 4'd0;
        end
        RELEASE: begin
          if (sample != 2'b00) begin
            cnt <= 4'd0;
          end else if (cnt == DB - 4'd1) begin
            state <= HOLDOFF;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLDOFF: begin
          if (cnt == GP - 4'd1) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef COIN_TALLY_EN
  logic [7:0] add;
  logic [8:0] sum;

  // the registered coin code is already the value in 5-cent units
  assign add = {6'd0, coin};
  assign sum = {1'b0, tally} + {1'b0, add};

  always_ff @(posedge clock) begin
    if (reset) begin
      tally <= 8'd0;
    end else if (state == EMIT) begin
      if (tally_clr) tally <= add;
      else           tally <= sum[8] ? 8'hFF : sum[7:0];
    end else if (tally_clr) begin
      tally <= 8'd0;
    end
  end
`endif

endmodule
